// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch/LSU requesters, the arbiter and the memory.
// master = requester/memory side, slave = arbiter side.
interface mem_port_arbiter_if #(
    parameter int MEM_AW = 11
);
    logic              i_f_req;
    logic [31:0]       i_f_addr;
    logic              o_f_gnt;
    logic              o_f_rvalid;
    logic [31:0]       o_f_rdata;

    logic              i_l_req;
    logic              i_l_wren;
    logic [31:0]       i_l_addr;
    logic [31:0]       i_l_wdata;
    logic [3:0]        i_l_mask;
    logic              o_l_gnt;
    logic              o_l_rvalid;
    logic [31:0]       o_l_rdata;
    logic              o_l_err;

    logic [MEM_AW-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic [3:0]        o_mem_mask;
    logic              o_mem_wren;
    logic [31:0]       i_mem_rdata;

    logic              o_busy;

    modport master (
        output i_f_req, i_f_addr,
        output i_l_req, i_l_wren, i_l_addr, i_l_wdata, i_l_mask,
        output i_mem_rdata,
        input  o_f_gnt, o_f_rvalid, o_f_rdata,
        input  o_l_gnt, o_l_rvalid, o_l_rdata, o_l_err,
        input  o_mem_addr, o_mem_wdata, o_mem_mask, o_mem_wren,
        input  o_busy
    );

    modport slave (
        input  i_f_req, i_f_addr,
        input  i_l_req, i_l_wren, i_l_addr, i_l_wdata, i_l_mask,
        input  i_mem_rdata,
        output o_f_gnt, o_f_rvalid, o_f_rdata,
        output o_l_gnt, o_l_rvalid, o_l_rdata, o_l_err,
        output o_mem_addr, o_mem_wdata, o_mem_mask, o_mem_wren,
        output o_busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch + load/store) arbiter onto a single-cycle memory, one access per 2 cycles.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed LSU priority.
module mem_port_arbiter #(
    parameter int MEM_AW = 11
) (
    input logic              i_clk,
    input logic              i_reset,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [MEM_AW-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_mask;
    logic              req_wren;
    logic              req_lsu;
    logic              req_err;

    logic              grant_f;
    logic              grant_l;
    logic              l_addr_err;
    logic [3:0]        mem_mask;
    logic              mem_wren;

    assign l_addr_err = |bus.i_l_addr[31:MEM_AW];

`ifdef ARB_ROUND_ROBIN_EN
    logic last_lsu;

    // On a tie, the port that was not served last wins.
    always_comb begin
        grant_f = 1'b0;
        grant_l = 1'b0;
        if (state == IDLE && i_reset) begin
            if (bus.i_l_req && bus.i_f_req) begin
                grant_l = !last_lsu;
                grant_f = last_lsu;
            end else begin
                grant_l = bus.i_l_req;
                grant_f = bus.i_f_req;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            last_lsu <= 1'b0;
        end else if (grant_l || grant_f) begin
            last_lsu <= grant_l;
        end
    end
`else
    always_comb begin
        grant_f = 1'b0;
        grant_l = 1'b0;
        if (state == IDLE && i_reset) begin
            grant_l = bus.i_l_req;
            grant_f = bus.i_f_req && !bus.i_l_req;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Errored LSU accesses keep the memory completely quiet.
    always_comb begin
        state_next = state;
        mem_mask   = 4'h0;
        mem_wren   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_f || grant_l) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                state_next = IDLE;
                if (!req_err) begin
                    mem_mask = req_lsu ? req_mask : 4'hF;
                    mem_wren = req_lsu && req_wren && i_reset;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            req_addr  <= '0;
            req_wdata <= '0;
            req_mask  <= '0;
            req_wren  <= 1'b0;
            req_lsu   <= 1'b0;
            req_err   <= 1'b0;
        end else if (grant_l) begin
            req_addr  <= bus.i_l_addr[MEM_AW-1:0];
            req_wdata <= bus.i_l_wdata;
            req_mask  <= bus.i_l_mask;
            req_wren  <= bus.i_l_wren;
            req_lsu   <= 1'b1;
            req_err   <= l_addr_err;
        end else if (grant_f) begin
            req_addr  <= bus.i_f_addr[MEM_AW-1:0];
            req_wdata <= '0;
            req_mask  <= 4'hF;
            req_wren  <= 1'b0;
            req_lsu   <= 1'b0;
            req_err   <= 1'b0;
        end
    end

    // Read data is captured at the edge that ends ACCESS; rvalid shows it one cycle later.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            bus.o_f_rvalid <= 1'b0;
            bus.o_l_rvalid <= 1'b0;
            bus.o_l_err    <= 1'b0;
            bus.o_f_rdata  <= '0;
            bus.o_l_rdata  <= '0;
        end else begin
            bus.o_f_rvalid <= 1'b0;
            bus.o_l_rvalid <= 1'b0;
            if (state == ACCESS) begin
                if (req_lsu) begin
                    bus.o_l_rvalid <= 1'b1;
                    bus.o_l_err    <= req_err;
                    bus.o_l_rdata  <= (req_wren || req_err) ? 32'h0 : bus.i_mem_rdata;
                end else begin
                    bus.o_f_rvalid <= 1'b1;
                    bus.o_f_rdata  <= bus.i_mem_rdata;
                end
            end
        end
    end

    assign bus.o_f_gnt     = grant_f;
    assign bus.o_l_gnt     = grant_l;
    assign bus.o_mem_addr  = req_addr;
    assign bus.o_mem_wdata = req_wdata;
    assign bus.o_mem_mask  = mem_mask;
    assign bus.o_mem_wren  = mem_wren;
    assign bus.o_busy      = (state == ACCESS);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then random traffic,
// checked every cycle against a transaction-level model with its own reference memory.
module tb_mem_port_arbiter;

    localparam int MEM_AW = 11;
    localparam int WORDS  = 1 << (MEM_AW - 2);

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.MEM_AW(MEM_AW)) bus ();

    mem_port_arbiter #(.MEM_AW(MEM_AW)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    function automatic logic [31:0] lane_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    logic [31:0] env_mem [WORDS];
    logic [31:0] ref_mem [WORDS];

    assign bus.i_mem_rdata = env_mem[bus.o_mem_addr[MEM_AW-1:2]] & lane_mask(bus.o_mem_mask);

    always @(posedge clk) begin
        if (bus.o_mem_wren === 1'b1) begin
            env_mem[bus.o_mem_addr[MEM_AW-1:2]] <=
                (env_mem[bus.o_mem_addr[MEM_AW-1:2]] & ~lane_mask(bus.o_mem_mask)) |
                (bus.o_mem_wdata & lane_mask(bus.o_mem_mask));
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Transaction-level model: the access in flight, the response due now, held read data.
    typedef struct {
        logic        valid;
        logic        lsu;
        logic        wren;
        logic        err;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } txn_t;

    txn_t        acc;
    logic        resp_valid;
    logic        resp_lsu;
    logic        resp_err;
    logic [31:0] exp_f_rdata;
    logic [31:0] exp_l_rdata;
    logic        last_lsu;
    logic        model_ok;
    logic        exp_gnt_f;
    logic        exp_gnt_l;

    task automatic modelCheck();
        logic exp_wren;
        exp_gnt_f = 1'b0;
        exp_gnt_l = 1'b0;
        if (rst_n && model_ok && !acc.valid) begin
            if (bus.i_l_req && bus.i_f_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                exp_gnt_f = last_lsu;
                exp_gnt_l = !last_lsu;
`else
                exp_gnt_l = 1'b1;
`endif
            end else begin
                exp_gnt_f = bus.i_f_req;
                exp_gnt_l = bus.i_l_req;
            end
        end
        checkOutput("f_gnt", bus.o_f_gnt, exp_gnt_f);
        checkOutput("l_gnt", bus.o_l_gnt, exp_gnt_l);
        if (!model_ok) return;

        checkOutput("busy", bus.o_busy, acc.valid);
        checkOutput("f_rvalid", bus.o_f_rvalid, resp_valid && !resp_lsu);
        checkOutput("l_rvalid", bus.o_l_rvalid, resp_valid && resp_lsu);
        checkOutput("f_rdata", bus.o_f_rdata, exp_f_rdata);
        checkOutput("l_rdata", bus.o_l_rdata, exp_l_rdata);
        if (resp_valid && resp_lsu) checkOutput("l_err", bus.o_l_err, resp_err);

        exp_wren = acc.valid && acc.lsu && acc.wren && !acc.err && rst_n;
        checkOutput("mem_wren", bus.o_mem_wren, exp_wren);
        if (acc.valid) begin
            checkOutput("mem_addr", 32'(bus.o_mem_addr), 32'(acc.addr[MEM_AW-1:0]));
            checkOutput("mem_mask", bus.o_mem_mask, acc.err ? 4'h0 : (acc.lsu ? acc.mask : 4'hF));
            if (exp_wren) checkOutput("mem_wdata", bus.o_mem_wdata, acc.wdata);
        end else begin
            checkOutput("mem_mask_idle", bus.o_mem_mask, 4'h0);
        end
    endtask

    task automatic modelAdvance();
        int w;
        if (!rst_n) begin
            acc.valid   = 1'b0;
            resp_valid  = 1'b0;
            exp_f_rdata = '0;
            exp_l_rdata = '0;
            last_lsu    = 1'b0;
            model_ok    = 1'b1;
            return;
        end
        if (!model_ok) return;
        resp_valid = 1'b0;
        if (acc.valid) begin
            w          = int'(acc.addr[MEM_AW-1:2]);
            resp_valid = 1'b1;
            resp_lsu   = acc.lsu;
            resp_err   = acc.err;
            if (!acc.lsu) begin
                exp_f_rdata = ref_mem[w];
            end else if (acc.err) begin
                exp_l_rdata = '0;
            end else if (acc.wren) begin
                ref_mem[w]  = (ref_mem[w] & ~lane_mask(acc.mask)) | (acc.wdata & lane_mask(acc.mask));
                exp_l_rdata = '0;
            end else begin
                exp_l_rdata = ref_mem[w] & lane_mask(acc.mask);
            end
        end
        acc.valid = 1'b0;
        if (exp_gnt_l) begin
            acc.valid = 1'b1;
            acc.lsu   = 1'b1;
            acc.wren  = bus.i_l_wren;
            acc.err   = (bus.i_l_addr >= 32'(1 << MEM_AW));
            acc.addr  = bus.i_l_addr;
            acc.wdata = bus.i_l_wdata;
            acc.mask  = bus.i_l_mask;
            last_lsu  = 1'b1;
        end else if (exp_gnt_f) begin
            acc.valid = 1'b1;
            acc.lsu   = 1'b0;
            acc.wren  = 1'b0;
            acc.err   = 1'b0;
            acc.addr  = bus.i_f_addr;
            acc.wdata = '0;
            acc.mask  = 4'hF;
            last_lsu  = 1'b0;
        end
    endtask

    task automatic stepCycle();
        @(negedge clk);
        modelCheck();
        modelAdvance();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic fr, input logic [31:0] fa, input logic lr,
                                 input logic lw, input logic [31:0] la, input logic [31:0] ld,
                                 input logic [3:0] lm);
        bus.i_f_req   = fr;
        bus.i_f_addr  = fa;
        bus.i_l_req   = lr;
        bus.i_l_wren  = lw;
        bus.i_l_addr  = la;
        bus.i_l_wdata = ld;
        bus.i_l_mask  = lm;
    endtask

    task automatic idleCycles(input int n);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    initial begin
        int bad_words;
        model_ok = 1'b0;
        acc.valid = 1'b0;
        resp_valid = 1'b0;
        last_lsu = 1'b0;
        exp_f_rdata = '0;
        exp_l_rdata = '0;
        for (int i = 0; i < WORDS; i++) begin
            env_mem[i] = $urandom();
            ref_mem[i] = env_mem[i];
        end

        rst_n = 1'b0;
        idleCycles(2);
        rst_n = 1'b1;
        idleCycles(1);

        // Single fetch from address 0.
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        stepCycle();
        idleCycles(3);

        // Partial store then full load of the same word.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'b0011);
        stepCycle();
        idleCycles(1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        stepCycle();
        idleCycles(3);

        // Both ports requesting continuously for six cycles.
        applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'h0, 4'hF);
        for (int i = 0; i < 6; i++) stepCycle();
        idleCycles(3);

        // Out-of-range store must error and leave memory untouched.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0800, 32'hCAFEF00D, 4'hF);
        stepCycle();
        idleCycles(3);

        // Reset during the ACCESS cycle of a store aborts it.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 32'h12345678, 4'hF);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst_n = 1'b0;
        stepCycle();
        rst_n = 1'b1;
        idleCycles(3);

        // Random traffic: requests held until granted, occasional drops and resets.
        for (int c = 0; c < 3000; c++) begin
            if (!bus.i_f_req) begin
                if ($urandom_range(0, 1) == 1) begin
                    bus.i_f_req  = 1'b1;
                    bus.i_f_addr = $urandom() & ~32'h3;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                bus.i_f_req = 1'b0;
            end
            if (!bus.i_l_req) begin
                if ($urandom_range(0, 1) == 1) begin
                    bus.i_l_req   = 1'b1;
                    bus.i_l_wren  = 1'($urandom_range(0, 1));
                    bus.i_l_addr  = ($urandom_range(0, 7) == 0) ?
                                    (($urandom() | 32'h800) & ~32'h3) : ($urandom() & 32'h7FC);
                    bus.i_l_wdata = $urandom();
                    bus.i_l_mask  = 4'($urandom_range(0, 15));
                end
            end else if ($urandom_range(0, 15) == 0) begin
                bus.i_l_req = 1'b0;
            end
            rst_n = ($urandom_range(0, 49) != 0);
            stepCycle();
            if (exp_gnt_f) bus.i_f_req = 1'b0;
            if (exp_gnt_l) bus.i_l_req = 1'b0;
        end
        rst_n = 1'b1;
        idleCycles(4);

        bad_words = 0;
        for (int i = 0; i < WORDS; i++) begin
            if (env_mem[i] !== ref_mem[i]) bad_words++;
        end
        checkOutput("mem_final", 32'(bad_words), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: MEM_AW, 11, memory byte-address width; memory spans 2^MEM_AW bytes.
REQ-002 i_clk  in  1  clock; all state updates on rising edge.
REQ-003 i_reset  in  1  reset, synchronous, active-low.
REQ-004 i_f_req  in  1  fetch request; held with i_f_addr stable until o_f_gnt.
REQ-005 i_f_addr  in  32  fetch byte address.
REQ-006 o_f_gnt  out  1  fetch request accepted this cycle (combinational, IDLE only).
REQ-007 o_f_rvalid  out  1  fetch data valid, one-cycle pulse.
REQ-008 o_f_rdata  out  32  fetch read data.
REQ-009 i_l_req  in  1  load/store request; held with all l-inputs stable until o_l_gnt.
REQ-010 i_l_wren  in  1  1 = store, 0 = load.
REQ-011 i_l_addr  in  32  load/store byte address.
REQ-012 i_l_wdata  in  32  store data.
REQ-013 i_l_mask  in  4  byte-lane mask.
REQ-014 o_l_gnt  out  1  load/store request accepted this cycle (combinational, IDLE only).
REQ-015 o_l_rvalid  out  1  load data / store ack valid, one-cycle pulse.
REQ-016 o_l_rdata  out  32  load data; 0 for stores and errors.
REQ-017 o_l_err  out  1  qualified by o_l_rvalid; address out of range.
REQ-018 o_mem_addr  out  MEM_AW  memory byte address.
REQ-019 o_mem_wdata  out  32  memory write data.
REQ-020 o_mem_mask  out  4  memory byte mask.
REQ-021 o_mem_wren  out  1  memory write enable.
REQ-022 i_mem_rdata  in  32  memory combinational read data (mask-gated by memory).
REQ-023 o_busy  out  1  high while in ACCESS.

Function
REQ-024 FSM states IDLE, ACCESS; IDLE with winning request -> ACCESS; ACCESS -> IDLE unconditionally.
REQ-025 In IDLE, grant at most one requester; winner's address, wdata, mask, wren and identity latched into request registers at the clock edge.
REQ-026 Default arbitration: i_l_req beats i_f_req when both high.
REQ-027 In ACCESS, memory driven from latched request: o_mem_addr = addr[MEM_AW-1:0]; fetch uses mask 4'hF, wren 0.
REQ-028 In IDLE, o_mem_mask = 0 and o_mem_wren = 0; o_mem_addr/o_mem_wdata hold latched values.
REQ-029 o_mem_wren = ACCESS & latched store & !latched error & i_reset; memory write occurs at the ACCESS-ending edge.
REQ-030 i_mem_rdata registered at end of ACCESS into requester's rdata; matching rvalid pulses the following cycle (grant-to-rvalid latency 2 cycles).
REQ-031 o_*_rdata holds last value until next response of that port.
REQ-032 Error: LSU request with addr[31:MEM_AW] != 0 -> no memory write, o_mem_mask = 0 in ACCESS, o_l_rvalid with o_l_err = 1, o_l_rdata = 0; fetch addresses truncated, no error.
REQ-033 Back-to-back: rvalid cycle is an IDLE cycle and may grant a new request; throughput one access per 2 cycles.
REQ-034 Requests dropped before grant are ignored; no request is queued beyond the single latched request.

Reset
REQ-035 While i_reset low at an edge: state -> IDLE, latched request cleared, o_f_rvalid, o_l_rvalid, o_l_err -> 0, o_f_rdata, o_l_rdata -> 0, round-robin pointer -> fetch-last.
REQ-036 Reset asserted in ACCESS aborts the access: o_mem_wren low that cycle, no rvalid issued.
REQ-037 Grants suppressed (o_f_gnt = o_l_gnt = 0) while i_reset low.

Configuration
REQ-038 Macro ARB_ROUND_ROBIN_EN defined: one-bit last-served pointer; on simultaneous requests grant the port not served last; pointer updates on every grant.
REQ-039 Macro undefined: fixed LSU priority per REQ-026, no pointer register.

Verification
REQ-040 Fetch only, i_f_addr=0x0 after reset -> o_f_gnt cycle 0, o_f_rvalid cycle 2, o_f_rdata = word at bytes 0..3.
REQ-041 Store i_l_addr=0x100, wdata=0xDEADBEEF, mask=4'b0011, then load same addr mask=4'hF -> o_l_rdata = 0xXXXXBEEF with bytes 2..3 unchanged.
REQ-042 i_f_req and i_l_req held high 6 cycles -> without macro only LSU granted (cycles 0,2,4); with macro grants L,F,L.
REQ-043 Store to i_l_addr=0x0000_0800 -> o_mem_wren never high, o_l_rvalid with o_l_err=1, memory unchanged.
REQ-044 Store granted, i_reset low in ACCESS cycle -> o_mem_wren=0, no o_l_rvalid, state IDLE after edge.
